// File: rtl/ung_pkg.sv
// ung_pkg: constants, skip-11 tap rows and checker state shared by the URN generator and checker.
package ung_pkg;
    localparam int URN_WIDTH  = 64;
    localparam int SKIP_CYCLE = 11;
    // Row i selects the bits of v that XOR into new bit i after 11 shifts of x^64+x^63+x^61+x^60+1.
    localparam logic [URN_WIDTH-1:0] TAP_ROWS [SKIP_CYCLE] = '{
        64'h0036_0000_0000_0000,
        64'h006C_0000_0000_0000,
        64'h00D8_0000_0000_0000,
        64'h01B0_0000_0000_0000,
        64'h0360_0000_0000_0000,
        64'h06C0_0000_0000_0000,
        64'h0D80_0000_0000_0000,
        64'h1B00_0000_0000_0000,
        64'h3600_0000_0000_0000,
        64'h6C00_0000_0000_0000,
        64'hD800_0000_0000_0000
    };
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} chk_state_e;
endpackage

// File: rtl/ung64_step.sv
// ung64_step: combinational skip-11 next-vector function of the 64-bit URN generator.
module ung64_step
    import ung_pkg::*;
(
    input  logic [URN_WIDTH-1:0] v_i,
    output logic [URN_WIDTH-1:0] v_o
);
    always_comb begin
        v_o = {v_i[URN_WIDTH-SKIP_CYCLE-1:0], {SKIP_CYCLE{1'b0}}};
        for (int i = 0; i < SKIP_CYCLE; i++) v_o[i] = ^(v_i & TAP_ROWS[i]);
    end
endmodule

// File: rtl/ung64_checker.sv
// ung64_checker: acquires lock on a URN stream by prediction, then freewheels and counts errors.
module ung64_checker
    import ung_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
)(
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] data_in,
    input  logic        valid_in,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] err_count,
    output logic [47:0] word_count
);
    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);
    chk_state_e  state_q, state_d;
    logic [63:0] pred_q, pred_d, data_step, pred_step;
    logic [3:0]  match_q, match_d, miss_q, miss_d;
    logic [31:0] err_count_q;
    logic [47:0] word_count_q;
    logic        locked_q, err_pulse_q, hit, err, count_word;

    ung64_step u_step_data (.v_i(data_in), .v_o(data_step));
    ung64_step u_step_pred (.v_i(pred_q),  .v_o(pred_step));

    assign hit        = data_in == pred_q;
    assign count_word = valid_in && state_q == LOCKED;
    assign err        = count_word && !hit;

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        miss_d  = miss_q;
        if (valid_in) begin
            case (state_q)
                HUNT: if (data_in != '0) begin
                    pred_d  = data_step;
                    match_d = '0;
                    state_d = SYNC;
                end
                SYNC: if (hit) begin
                    pred_d  = data_step;
                    match_d = match_q + 4'd1;
                    state_d = match_d == LOCK_N ? LOCKED : SYNC;
                end else if (data_in != '0) begin
                    pred_d  = data_step;
                    match_d = '0;
                end else begin
                    state_d = HUNT;
                end
                LOCKED: begin
                    pred_d = pred_step;
                    miss_d = hit ? 4'd0 : miss_q + 4'd1;
                    if (miss_d == LOSS_N) begin
                        state_d = HUNT;
                        match_d = '0;
                        miss_d  = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= HUNT;
            pred_q       <= '0;
            match_q      <= '0;
            miss_q       <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pred_q       <= pred_d;
            match_q      <= match_d;
            miss_q       <= miss_d;
            locked_q     <= state_d == LOCKED;
            err_pulse_q  <= err;
            err_count_q  <= clear ? '0 : (err && err_count_q != '1) ? err_count_q + 32'd1 : err_count_q;
            word_count_q <= clear ? '0 : (count_word && word_count_q != '1) ? word_count_q + 48'd1 : word_count_q;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;
endmodule

// File: tb/tb_ung64_checker.sv
// tb_ung64_checker: directed acquisition, error, loss/relock, lock-up and clear/saturation checks.
module tb_ung64_checker;
    logic        clk = 1'b0, rstn = 1'b0, valid_in = 1'b0, clear = 1'b0;
    logic [63:0] data_in = '0;
    logic        locked, err_pulse;
    logic [31:0] err_count;
    logic [47:0] word_count;
    logic [63:0] w [1:45];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    ung64_checker dut (
        .clk(clk), .rstn(rstn), .data_in(data_in), .valid_in(valid_in), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count)
    );

    // Independent serial Fibonacci LFSR, clocked 11 times per word.
    function automatic logic [63:0] lfsr11(input logic [63:0] v);
        for (int k = 0; k < 11; k++) v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic feed(input logic [63:0] d, input logic v = 1'b1, input logic c = 1'b0);
        @(negedge clk);
        data_in  = d;
        valid_in = v;
        clear    = c;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        w[1] = 64'h45D0_00FF_FFF0_05FF;
        for (int n = 2; n <= 45; n++) w[n] = lfsr11(w[n-1]);
        // reset with valid/clear active must be ignored
        valid_in = 1'b1;
        clear    = 1'b1;
        data_in  = w[1];
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_count", err_count, 0);
        check("rst_word_count", word_count, 0);
        @(negedge clk);
        rstn     = 1'b1;
        valid_in = 1'b0;
        clear    = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            feed(w[n]);
            if (n == 4) check("lock_early", locked, 0);
            if (n == 5) check("lock_w5", locked, 1);
            if (n == 5) check("lock_err_count", err_count, 0);
        end
        check("word_count_w19", word_count, 14);
        feed(w[20] ^ 64'h1);
        check("err_pulse_w20", err_pulse, 1);
        check("err_count_w20", err_count, 1);
        check("locked_w20", locked, 1);
        feed(w[21]);
        check("err_pulse_w21", err_pulse, 0);
        check("err_count_w21", err_count, 1);
        for (int n = 22; n <= 29; n++) feed(w[n]);
        feed(w[30] ^ 64'h8000_0000_0000_0000);
        feed(w[31] ^ 64'h1);
        check("locked_w31", locked, 1);
        feed(w[32] ^ 64'h10);
        check("locked_w32", locked, 0);
        check("err_count_w32", err_count, 4);
        check("word_count_w32", word_count, 27);
        for (int n = 33; n <= 37; n++) begin
            feed(w[n]);
            if (n == 33) check("err_pulse_hunt", err_pulse, 0);
            if (n == 36) check("relock_early", locked, 0);
        end
        check("relock_w37", locked, 1);
        feed(64'h0, 1'b0);
        check("idle_locked", locked, 1);
        check("idle_word_count", word_count, 27);
        feed(w[38] ^ 64'h1, 1'b1, 1'b1);
        check("clr_err_count", err_count, 0);
        check("clr_err_pulse", err_pulse, 1);
        check("clr_word_count", word_count, 0);
        @(negedge clk);
        force dut.err_count_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.err_count_q;
        check("sat_preload", err_count, 64'hFFFF_FFFF);
        feed(w[39]);
        feed(w[40] ^ 64'h2);
        check("sat_err_count", err_count, 64'hFFFF_FFFF);
        check("sat_err_pulse", err_pulse, 1);
        check("sat_locked", locked, 1);
        check("sat_word_count", word_count, 2);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_locked", locked, 0);
        check("midrst_err_count", err_count, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) feed(64'h0);
        check("zero_locked", locked, 0);
        check("zero_word_count", word_count, 0);
        feed(w[1]);
        feed(w[2]);
        feed(64'h0);
        for (int n = 1; n <= 5; n++) begin
            feed(w[n]);
            if (n == 4) check("reacq_early", locked, 0);
        end
        check("reacq_w5", locked, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ung64_checker.md
UNG64_CHECKER -- requirements
Module: ung64_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4, sets the number of consecutive predicted-word matches needed to declare lock (range 1..15).
REQ-002 Parameter LOSS_CNT, default 3, sets the number of consecutive mismatches while locked that drops lock (range 1..15).
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rstn  input  1  reset, synchronous and active-low.
REQ-005 Port: data_in  input  64  URN word from the uniform number generator.
REQ-006 Port: valid_in  input  1  data_in qualifier; one word is consumed per cycle while high.
REQ-007 Port: clear  input  1  synchronous clear of err_count and word_count; lock state is unaffected.
REQ-008 Port: locked  output  1  high while the FSM is in LOCKED.
REQ-009 Port: err_pulse  output  1  one-cycle pulse for each mismatching word while LOCKED.
REQ-010 Port: err_count  output  32  saturating count of mismatches while LOCKED.
REQ-011 Port: word_count  output  48  saturating count of valid words consumed while LOCKED.

Function
REQ-012 Define step(v) as the generator's skip-11 next-vector function: bits [63:11] = v[52:0]; bits [10:0] = the XOR tap rows held in the shared package.
REQ-013 The FSM has three states: HUNT, SYNC and LOCKED; the reset state is HUNT.
REQ-014 The FSM and all registers hold their values in any cycle where valid_in=0.
REQ-015 HUNT, on valid_in with data_in != 0: pred <= step(data_in), match_run <= 0, next state SYNC.
REQ-016 HUNT, on valid_in with data_in == 0 (the LFSR lock-up value): remain in HUNT; pred is unchanged.
REQ-017 SYNC, on a match (data_in == pred): match_run increments and pred <= step(data_in).
REQ-018 SYNC: when match_run reaches LOCK_CNT, the next state is LOCKED.
REQ-019 SYNC, on a mismatch with nonzero data_in: pred <= step(data_in) (re-seed), match_run <= 0, remain in SYNC.
REQ-020 SYNC, on a mismatch with data_in == 0: return to HUNT.
REQ-021 LOCKED is freewheeling: on every valid word, pred <= step(pred) regardless of data_in, and word_count increments.
REQ-022 LOCKED, on a match: miss_run <= 0.
REQ-023 LOCKED, on a mismatch: err_pulse=1 in the next cycle, err_count increments, miss_run increments.
REQ-024 LOCKED: when miss_run reaches LOSS_CNT, the next state is HUNT and match_run and miss_run are cleared.
REQ-025 All outputs are registered, with latency 1 cycle from the valid_in edge.
REQ-026 locked rises in the cycle after the LOCK_CNT-th match; locked falls in the cycle after the LOSS_CNT-th consecutive miss.
REQ-027 err_count and word_count saturate at all-ones and never wrap.
REQ-028 clear has priority over increment: a clear coincident with an error gives err_count=0, and err_pulse still asserts.
REQ-029 Comparisons are full 64-bit equality; there is no partial-match tolerance.

Reset
REQ-030 With rstn=0 at a clock edge: state=HUNT, pred=0, match_run=0, miss_run=0, locked=0, err_pulse=0, err_count=0, word_count=0.
REQ-031 Reset mid-stream discards lock immediately; the following valid words restart acquisition from HUNT.
REQ-032 valid_in and clear are ignored while rstn=0.

Structure
REQ-033 Shared package ung_pkg holds URN_WIDTH=64, SKIP_CYCLE=11, the 11 tap-row constants for bits [10:0], and the checker state enum.
REQ-034 The generator and this checker both use the ung_pkg taps, so the two ends cannot diverge.
REQ-035 One combinational sub-module, ung64_step (64-bit in, 64-bit out = step), is instantiated twice: once on data_in and once on pred.

Verification
REQ-036 Reset: hold rstn=0 for 3 cycles -> locked=0, err_pulse=0, err_count=0, word_count=0.
REQ-037 Acquire: feed the clean generator stream from seed 0x45D000FFFFF005FF at one word per cycle -> locked=1 in the cycle after word 5 and err_count=0.
REQ-038 Single error: after lock, flip bit 0 of word 20 -> one err_pulse, err_count=1, locked stays 1, and word 21 matches.
REQ-039 Loss and relock: corrupt words 30-32 -> locked=0 after word 32 with err_count=4; with clean words from 33, locked=1 after word 37.
REQ-040 Lock-up value: in HUNT, feed data_in=0 ten times -> state stays HUNT and locked=0; word_count does not count the zero words.
REQ-041 Clear collision: assert clear in the same cycle as a locked-state error -> err_count=0 next cycle and err_pulse=1; force err_count to all-ones, inject an error -> err_count remains 0xFFFFFFFF.
